// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer: splits one vector access into LANES word transactions
// at base + i*stride, gathering loads into one register write or scattering a store.
module vector_mem_sequencer #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    op,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       stride,
  input  logic [4:0]              vreg_idx,
  input  logic [LANES*LANE_W-1:0] vec_rdata,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_wr_en,
  output logic [LANE_W-1:0]       mem_wdata,
  input  logic [LANE_W-1:0]       mem_rdata,
  output logic                    vec_we,
  output logic [4:0]              vec_waddr,
  output logic [LANES*LANE_W-1:0] vec_wdata
);
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         op_q, op_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [ADDR_W-1:0]            stride_q, stride_d;
  logic [4:0]                   vreg_q, vreg_d;
  logic [4:0]                   waddr_q, waddr_d;
  logic [LANES-1:0][LANE_W-1:0] src_q, src_d;
  logic [LANES-1:0][LANE_W-1:0] buf_q, buf_d;
  logic [LANES-1:0][LANE_W-1:0] vout_q, vout_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      addr_q   <= '0;
      stride_q <= '0;
      vreg_q   <= '0;
      waddr_q  <= '0;
      src_q    <= '0;
      buf_q    <= '0;
      vout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      vreg_q   <= vreg_d;
      waddr_q  <= waddr_d;
      src_q    <= src_d;
      buf_q    <= buf_d;
      vout_q   <= vout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    vreg_d   = vreg_q;
    waddr_d  = waddr_q;
    src_d    = src_q;
    buf_d    = buf_q;
    vout_d   = vout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          addr_d   = base_addr;
          stride_d = stride;
          vreg_d   = vreg_idx;
          src_d    = vec_rdata;
          cnt_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // Read data lags the address by one cycle, so lane i-1 lands while lane i issues.
        if (!op_q && cnt_q != '0)
          buf_d[cnt_q - CNT_W'(1)] = mem_rdata;
        if (cnt_q == LAST) begin
          state_d = op_q ? FINISH : DRAIN;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          addr_d = addr_q + stride_q;
        end
      end
      DRAIN: begin
        // Separate output copy keeps vec_wdata stable while a later load refills buf_q.
        vout_d          = buf_q;
        vout_d[LANES-1] = mem_rdata;
        waddr_d         = vreg_q;
        state_d         = FINISH;
      end
      FINISH: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign mem_addr  = addr_q;
  assign mem_wr_en = (state_q == ISSUE) && op_q;
  assign mem_wdata = mem_wr_en ? src_q[cnt_q] : '0;
  assign vec_we    = (state_q == FINISH) && !op_q;
  assign vec_waddr = waddr_q;
  assign vec_wdata = vout_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Randomized bench for vector_mem_sequencer against a lane-list reference model
// with a 1K-word data memory and a 32-entry vector register file model.
module tb_vector_mem_sequencer;
  localparam int L  = 4;
  localparam int W  = 32;
  localparam int VW = L * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [31:0]   stride = '0;
  logic [4:0]    vreg_idx = '0;
  logic [VW-1:0] vec_rdata = '0;
  logic          busy, done, mem_wr_en, vec_we;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [4:0]    vec_waddr;
  logic [VW-1:0] vec_wdata;

  vector_mem_sequencer #(.LANES(L), .LANE_W(W), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .base_addr(base_addr),
    .stride(stride), .vreg_idx(vreg_idx), .vec_rdata(vec_rdata), .busy(busy),
    .done(done), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .vec_we(vec_we), .vec_waddr(vec_waddr), .vec_wdata(vec_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hashf(input logic [9:0] ix);
    return ({22'h0, ix} * 32'h9E3779B1) ^ 32'hC0FFEE11;
  endfunction

  // Memory seen by the DUT: word-indexed by addr[11:2], unwritten words read a hash.
  logic [31:0] tbmem [0:1023];
  bit          tbw   [0:1023];
  always @(posedge clk) begin
    mem_rdata <= tbw[mem_addr[11:2]] ? tbmem[mem_addr[11:2]] : hashf(mem_addr[11:2]);
    if (mem_wr_en) begin
      tbmem[mem_addr[11:2]] <= mem_wdata;
      tbw[mem_addr[11:2]]   <= 1'b1;
    end
  end

  int done_cnt = 0, we_cnt = 0, wr_cnt = 0;
  always @(negedge clk) begin
    if (done)      done_cnt <= done_cnt + 1;
    if (vec_we)    we_cnt   <= we_cnt + 1;
    if (mem_wr_en) wr_cnt   <= wr_cnt + 1;
  end

  // Reference state
  logic [31:0]   refmem [0:1023];
  bit            refw   [0:1023];
  logic [VW-1:0] vrf    [0:31];
  logic [VW-1:0] last_vec = '0;
  logic [4:0]    last_idx = '0;
  int            exp_done = 0, exp_we = 0, exp_wr = 0;
  int            n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refw[a[11:2]] ? refmem[a[11:2]] : hashf(a[11:2]);
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called in the low phase of an IDLE cycle; returns in the low phase of the cycle after done.
  task automatic run_op(input bit t_op, input logic [31:0] t_base, input logic [31:0] t_stride,
                        input logic [4:0] t_vr, input bit t_hold);
    int            lat;
    logic [VW-1:0] v, ev;
    logic [31:0]   a;
    lat = t_op ? L + 1 : L + 2;
    v   = vrf[t_vr];
    ev  = '0;
    for (int i = 0; i < L; i++) begin
      a = t_base + t_stride * 32'(i);
      if (t_op) begin
        refmem[a[11:2]] = v[i*W +: W];
        refw[a[11:2]]   = 1'b1;
      end else begin
        ev[i*W +: W] = ref_rd(a);
      end
    end
    start = 1'b1; op = t_op; base_addr = t_base; stride = t_stride;
    vreg_idx = t_vr; vec_rdata = v;
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      if (n <= L) begin
        a = t_base + t_stride * 32'(n - 1);
        chk("mem_addr", mem_addr, a);
        chk("mem_wr_en", mem_wr_en, t_op);
        if (t_op) chk("mem_wdata", mem_wdata, v[(n-1)*W +: W]);
      end
      chk("busy", busy, n <= lat);
      chk("done", done, n == lat);
      chk("vec_we", vec_we, (n == lat) && !t_op);
      if (n == lat) begin
        if (!t_op) begin
          last_vec = ev;
          last_idx = t_vr;
        end
        chk("vec_wdata", vec_wdata, last_vec);
        chk("vec_waddr", vec_waddr, last_idx);
      end
      if (t_hold && n <= lat) begin
        start = 1'b1; op = 1'($urandom); base_addr = $urandom; stride = $urandom;
        vreg_idx = 5'($urandom); vec_rdata = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
    end
    if (t_op) exp_wr += L;
    else begin
      vrf[t_vr] = ev;
      exp_we++;
    end
    exp_done++;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [VW-1:0] v;
    logic [31:0]   rs;
    for (int i = 0; i < 32; i++) vrf[i] = {$urandom, $urandom, $urandom, $urandom};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wr_en", mem_wr_en, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_vec_we", vec_we, 0);
    chk("rst_vec_waddr", vec_waddr, 0);
    chk("rst_vec_wdata", vec_wdata, 0);
    reset = 1'b0;

    // Basic load: memory at 0x100.. holds 11,22,33,44 (placed by a store).
    vrf[1] = {32'h44, 32'h33, 32'h22, 32'h11};
    run_op(1'b1, 32'h100, 32'h4, 5'd1, 1'b0);
    run_op(1'b0, 32'h100, 32'h4, 5'd2, 1'b0);
    chk("load_vec", vec_wdata, {32'h44, 32'h33, 32'h22, 32'h11});

    // Negative stride store, read back in ascending order.
    vrf[5] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    run_op(1'b1, 32'h200, -32'sd8, 5'd5, 1'b0);
    run_op(1'b0, 32'h1E8, 32'h8, 5'd6, 1'b0);
    chk("neg_stride_vec", vec_wdata,
        {32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD});

    // Address wrap-around
    run_op(1'b0, 32'hFFFF_FFF8, 32'h4, 5'd9, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF8, 32'h4, 5'd9, 1'b0);

    // start held high throughout: one op each, next accepted right after done
    run_op(1'b0, 32'h40, 32'h4, 5'd10, 1'b1);
    run_op(1'b1, 32'h80, -32'sd4, 5'd10, 1'b1);
    run_op(1'b0, 32'h74, 32'h4, 5'd11, 1'b0);

    // Reset in the middle of a store, after lanes 0 and 1 have been written
    v = vrf[7];
    start = 1'b1; op = 1'b1; base_addr = 32'h300; stride = 32'h4; vreg_idx = 5'd7; vec_rdata = v;
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      start = 1'b0;
      chk("abort_addr", mem_addr, 32'h300 + 32'(4 * (n - 1)));
      chk("abort_wdata", mem_wdata, v[(n-1)*W +: W]);
    end
    for (int i = 0; i < 2; i++) begin
      refmem[(32'h300 >> 2) + i] = v[i*W +: W];
      refw[(32'h300 >> 2) + i]   = 1'b1;
    end
    exp_wr += 2;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", mem_wr_en, 0);
    chk("abort_addr0", mem_addr, 0);
    chk("abort_done", done, 0);
    chk("abort_vec_wdata", vec_wdata, 0);
    last_vec = '0;
    last_idx = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_done", done, 0);
      chk("post_abort_busy", busy, 0);
    end
    run_op(1'b0, 32'h300, 32'h4, 5'd8, 1'b0);

    // Back-to-back load then store of the same register
    run_op(1'b0, 32'h400, 32'd12, 5'd3, 1'b0);
    run_op(1'b1, 32'h600, 32'h4, 5'd3, 1'b0);
    run_op(1'b0, 32'h600, 32'h4, 5'd4, 1'b0);
    chk("b2b_vec", vec_wdata, vrf[3]);

    // Random mix
    repeat (30) begin
      case ($urandom_range(0, 5))
        0: rs = 32'h4;
        1: rs = -32'sd4;
        2: rs = 32'h8;
        3: rs = -32'sd16;
        4: rs = 32'h0;
        default: rs = $urandom;
      endcase
      run_op(1'($urandom), ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom, rs,
             5'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    chk("done_count", done_cnt, exp_done);
    chk("vec_we_count", we_cnt, exp_we);
    chk("mem_wr_count", wr_cnt, exp_wr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
